shift_operand_stage: RTL and testbench



---
 rtl/shift_operand_stage.sv | 102 ++++++++++
 tb/tb_shift_operand_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_operand_stage.sv
// Execute-entry stage: decodes R-type shift funct into barrel-shifter controls and
// buffers the result in a two-entry (main + skid) valid/ready pipeline register.
module shift_operand_stage (
  input  logic        clk,
  input  logic        clrn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic [4:0]  sa,
  output logic [1:0]  sel,
  output logic [4:0]  wr_reg,
  output logic        illegal_op
);

  typedef enum logic [1:0] {
    SEL_SLL = 2'b00,
    SEL_SLR = 2'b01,
    SEL_SAL = 2'b10,
    SEL_SAR = 2'b11
  } sel_e;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  sa;
    sel_e        sel;
    logic [4:0]  wr_reg;
  } entry_t;

  entry_t main_q, skid_q, dec;
  logic   main_v, skid_v;
  logic   dec_legal, accept, wr;
  logic   unused_rs_hi;

  // Only the low five bits of rs select a variable shift amount.
  assign unused_rs_hi = ^rs_val[31:5];

  always_comb begin
    dec_legal  = 1'b1;
    dec.d      = rt_val;
    dec.sa     = shamt;
    dec.sel    = SEL_SLL;
    dec.wr_reg = rd;
    case (funct)
      6'b000000: dec.sel = SEL_SLL;
      6'b000010: dec.sel = SEL_SLR;
      6'b000011: dec.sel = SEL_SAR;
      6'b000100: begin dec.sel = SEL_SLL; dec.sa = rs_val[4:0]; end
      6'b000110: begin dec.sel = SEL_SLR; dec.sa = rs_val[4:0]; end
      6'b000111: begin dec.sel = SEL_SAR; dec.sa = rs_val[4:0]; end
      default:   dec_legal = 1'b0;
    endcase
  end

  assign in_ready = ~skid_v;
  assign accept   = in_valid & in_ready;
  // Writes to r0 and illegal functs are consumed without producing an entry.
  assign wr       = accept & dec_legal & (rd != '0) & ~flush;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= accept & ~dec_legal & ~flush;
      if (flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end else if (!main_v || out_ready) begin
        if (skid_v) begin
          main_q <= skid_q;
          main_v <= 1'b1;
          skid_v <= wr;
          if (wr) skid_q <= dec;
        end else begin
          main_v <= wr;
          if (wr) main_q <= dec;
        end
      end else if (wr) begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
    end
  end

  assign out_valid = main_v;
  assign d         = main_q.d;
  assign sa        = main_q.sa;
  assign sel       = main_q.sel;
  assign wr_reg    = main_q.wr_reg;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Directed vector table, hand-written back-pressure/flush/reset sequences and a
// randomized streaming run against a reference queue for shift_operand_stage.
module tb_shift_operand_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic        in_valid, in_ready;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rs_val, rt_val;
  logic [4:0]  rd;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] d;
  logic [4:0]  sa;
  logic [1:0]  sel;
  logic [4:0]  wr_reg;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  shift_operand_stage dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val), .rd(rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .sa(sa), .sel(sel), .wr_reg(wr_reg), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic        ev;
    logic        eill;
    logic [31:0] ed;
    logic [4:0]  esa;
    logic [1:0]  esel;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] r);
    funct = f; shamt = sh; rs_val = rs; rt_val = rt; rd = r; in_valid = 1'b1;
  endtask

  // Reference decode used by the streaming scoreboard.
  function automatic logic [43:0] model(input logic [5:0] f, input logic [4:0] sh,
                                       input logic [31:0] rs, input logic [31:0] rt,
                                       input logic [4:0] r);
    logic [4:0] a;
    logic [1:0] s;
    a = f[2] ? rs[4:0] : sh;
    case (f)
      6'd2, 6'd6: s = 2'b01;
      6'd3, 6'd7: s = 2'b11;
      default:    s = 2'b00;
    endcase
    return {rt, a, s, r};
  endfunction

  logic [43:0] expq[$];
  logic        mon_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [43:0] prev_out;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall && out_valid)
        chk("stall_stable", {20'd0, d, sa, sel, wr_reg}, {20'd0, prev_out});
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_extra: got %h expected none", {d, sa, sel, wr_reg});
        end else begin
          chk("stream_order", {20'd0, d, sa, sel, wr_reg}, {20'd0, expq.pop_front()});
        end
      end
      prev_stall = out_valid & ~out_ready;
      prev_out   = {d, sa, sel, wr_reg};
    end
  end

  initial begin
    logic [5:0] lf[6];
    logic [5:0] f;
    logic [4:0] sh, r;
    logic [31:0] rs, rt;
    int waited;

    lf[0] = 6'd0; lf[1] = 6'd2; lf[2] = 6'd3; lf[3] = 6'd4; lf[4] = 6'd6; lf[5] = 6'd7;

    vt[0]  = '{6'h00, 5'd4,  32'h0,         32'h0000_00F1, 5'd3,  1, 0, 32'h0000_00F1, 5'd4,  2'b00};
    vt[1]  = '{6'h07, 5'd9,  32'hFFFF_FFE3, 32'h8000_0000, 5'd5,  1, 0, 32'h8000_0000, 5'd3,  2'b11};
    vt[2]  = '{6'h06, 5'd0,  32'h0000_0025, 32'h0000_1234, 5'd7,  1, 0, 32'h0000_1234, 5'd5,  2'b01};
    vt[3]  = '{6'h02, 5'd31, 32'h0000_000A, 32'h5555_AAAA, 5'd31, 1, 0, 32'h5555_AAAA, 5'd31, 2'b01};
    vt[4]  = '{6'h03, 5'd0,  32'h0000_00FF, 32'hDEAD_BEEF, 5'd1,  1, 0, 32'hDEAD_BEEF, 5'd0,  2'b11};
    vt[5]  = '{6'h04, 5'd2,  32'h0000_003F, 32'h0000_0001, 5'd9,  1, 0, 32'h0000_0001, 5'd31, 2'b00};
    vt[6]  = '{6'h20, 5'd1,  32'h0,         32'h1111_1111, 5'd4,  0, 1, 32'h0,         5'd0,  2'b00};
    vt[7]  = '{6'h00, 5'd0,  32'h0,         32'h0,         5'd0,  0, 0, 32'h0,         5'd0,  2'b00};
    vt[8]  = '{6'h00, 5'd5,  32'h0,         32'h2222_2222, 5'd0,  0, 0, 32'h0,         5'd0,  2'b00};
    vt[9]  = '{6'h05, 5'd1,  32'h0,         32'h3333_3333, 5'd2,  0, 1, 32'h0,         5'd0,  2'b00};
    vt[10] = '{6'h00, 5'd1,  32'h0,         32'h0000_0002, 5'd2,  1, 0, 32'h0000_0002, 5'd1,  2'b00};

    clrn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    funct = '0; shamt = '0; rs_val = '0; rt_val = '0; rd = '0;
    repeat (2) step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_fields", {20'd0, d, sa, sel, wr_reg}, 64'd0);
    chk("rst_illegal", {63'd0, illegal_op}, 64'd0);
    clrn = 1'b1;
    step();

    // Directed decode table, one instruction per cycle with downstream always ready.
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].funct, vt[i].shamt, vt[i].rs, vt[i].rt, vt[i].rd);
      step();
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, {63'd0, vt[i].ev});
      chk($sformatf("vec%0d_illegal", i), {63'd0, illegal_op}, {63'd0, vt[i].eill});
      if (vt[i].ev)
        chk($sformatf("vec%0d_fields", i), {20'd0, d, sa, sel, wr_reg},
            {20'd0, vt[i].ed, vt[i].esa, vt[i].esel, vt[i].rd});
    end
    in_valid = 1'b0;
    step();
    chk("illegal_pulse_end", {63'd0, illegal_op}, 64'd0);
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    // Back-pressure: three stalled cycles, then release.
    out_ready = 1'b0;
    drive(6'h00, 5'd1, 32'h0, 32'h0000_00A0, 5'd1);
    step();
    chk("bp_a_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_a_ready", {63'd0, in_ready}, 64'd1);
    drive(6'h00, 5'd2, 32'h0, 32'h0000_00B0, 5'd2);
    step();
    chk("bp_b_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_b_hold", {32'd0, d}, 64'h0000_00A0);
    drive(6'h00, 5'd3, 32'h0, 32'h0000_00C0, 5'd3);
    step();
    chk("bp_c_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_c_hold", {32'd0, d}, 64'h0000_00A0);
    out_ready = 1'b1;
    step();
    chk("bp_rel_b", {32'd0, d}, 64'h0000_00B0);
    chk("bp_rel_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("bp_rel_c", {20'd0, d, sa, sel, wr_reg}, {20'd0, 32'h0000_00C0, 5'd3, 2'b00, 5'd3});
    drive(6'h00, 5'd4, 32'h0, 32'h0000_00D0, 5'd4);
    step();
    chk("bp_rel_d", {32'd0, d}, 64'h0000_00D0);
    in_valid = 1'b0;
    step();
    chk("bp_done", {63'd0, out_valid}, 64'd0);

    // Flush with both entries full and an input offered.
    out_ready = 1'b0;
    drive(6'h00, 5'd1, 32'h0, 32'h0000_0E01, 5'd6);
    step();
    drive(6'h00, 5'd1, 32'h0, 32'h0000_0E02, 5'd6);
    step();
    chk("fl_full", {62'd0, out_valid, in_ready}, 64'd2);
    drive(6'h00, 5'd1, 32'h0, 32'h0000_0E03, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_full_after", {62'd0, out_valid, in_ready}, 64'd1);
    out_ready = 1'b1;
    step();
    chk("fl_full_gone", {63'd0, out_valid}, 64'd0);
    // Flush while an input is actually accepted: it must be dropped.
    out_ready = 1'b0;
    drive(6'h00, 5'd1, 32'h0, 32'h0000_0F01, 5'd6);
    step();
    drive(6'h00, 5'd1, 32'h0, 32'h0000_0F02, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_accept_after", {62'd0, out_valid, in_ready}, 64'd1);
    step();
    chk("fl_accept_gone", {63'd0, out_valid}, 64'd0);
    drive(6'h20, 5'd1, 32'h0, 32'h0, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_illegal_suppressed", {63'd0, illegal_op}, 64'd0);

    // Asynchronous reset mid-stream with both entries valid.
    drive(6'h00, 5'd1, 32'h0, 32'h0000_0A01, 5'd7);
    step();
    drive(6'h07, 5'd1, 32'h3, 32'h0000_0A02, 5'd7);
    step();
    in_valid = 1'b0;
    chk("rs_full", {62'd0, out_valid, in_ready}, 64'd2);
    clrn = 1'b0;
    #1;
    chk("rs_async", {30'd0, out_valid, in_ready, d}, {30'd0, 2'b01, 32'h0});
    chk("rs_async_sel", {62'd0, sel}, 64'd0);
    step();
    clrn = 1'b1;
    step();
    chk("rs_after", {30'd0, out_valid, in_ready, d}, {30'd0, 2'b01, 32'h0});
    chk("rs_after_sel", {62'd0, sel}, 64'd0);

    // Randomized streaming with random downstream stalls.
    mon_en = 1'b1;
    for (int n = 0; n < 100; n++) begin
      f  = lf[$urandom_range(0, 5)];
      sh = 5'($urandom_range(0, 31));
      rs = $urandom();
      rt = $urandom();
      r  = 5'($urandom_range(1, 31));
      drive(f, sh, rs, rt, r);
      waited = 0;
      while (1) begin
        out_ready = 1'($urandom_range(0, 1));
        if (in_ready) begin
          expq.push_back(model(f, sh, rs, rt, r));
          step();
          break;
        end
        step();
        waited++;
        if (waited > 50) begin
          checks++; errors++;
          $display("FAIL stream_accept_timeout: got in_ready=0 expected 1 within 50 cycles");
          break;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    waited = 0;
    while (expq.size() != 0 && waited < 200) begin
      step();
      waited++;
    end
    step();
    chk("stream_drained", 64'(expq.size()), 64'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
